// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the line pair, frames bytes and folds E0/F0 prefixes into scancode events.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scancode_rx #(
    parameter int CLKFREQ_KHZ = 6500,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkps2,
    input  logic       dataps2,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       scancode_valid,
    output logic       frame_error
);

    localparam int TW = (CLKFREQ_KHZ > 2) ? $clog2(CLKFREQ_KHZ) : 1;
    localparam logic [TW-1:0] TLIM = TW'(CLKFREQ_KHZ - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            clkSync_q, dataSync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  filtClk_q, filtClk_d;
    logic [2:0]            bitCnt_q, bitCnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  extPend_q, extPend_d;
    logic                  relPend_q, relPend_d;
    logic [7:0]            scancode_q, scancode_d;
    logic                  extended_q, extended_d;
    logic                  released_q, released_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    logic fallEdge, timeout, dataBit, parityOk, frameGood;

    assign dataBit  = dataSync_q[1];
    assign fallEdge = filtClk_q && (filt_q == '0);
    assign timeout  = (state_q != IDLE) && (timer_q == TLIM);

`ifdef PS2_PARITY_CHECK_EN
    assign parityOk = ^{shift_q, parity_q};
`else
    logic unusedParity;
    assign unusedParity = parity_q;
    assign parityOk     = 1'b1;
`endif

    assign frameGood = dataBit && parityOk;

    // Timeout takes priority over a coincident edge, which is then dropped.
    always_comb begin
        state_d    = state_q;
        filt_d     = {filt_q[FILTER_LEN-2:0], clkSync_q[1]};
        filtClk_d  = filtClk_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        timer_d    = timer_q;
        extPend_d  = extPend_q;
        relPend_d  = relPend_q;
        scancode_d = scancode_q;
        extended_d = extended_q;
        released_d = released_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        if (filt_q == '1) begin
            filtClk_d = 1'b1;
        end else if (filt_q == '0) begin
            filtClk_d = 1'b0;
        end

        if (state_q == IDLE || fallEdge) begin
            timer_d = '0;
        end else if (timer_q != TLIM) begin
            timer_d = timer_q + 1'b1;
        end

        if (timeout) begin
            state_d = IDLE;
            error_d = 1'b1;
        end else if (fallEdge) begin
            case (state_q)
                IDLE: begin
                    if (!dataBit) begin
                        state_d  = DATA;
                        bitCnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {dataBit, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dataBit;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!frameGood) begin
                        error_d   = 1'b1;
                        extPend_d = 1'b0;
                        relPend_d = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        extPend_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        relPend_d = 1'b1;
                    end else begin
                        scancode_d = shift_q;
                        extended_d = extPend_q;
                        released_d = relPend_q;
                        valid_d    = 1'b1;
                        extPend_d  = 1'b0;
                        relPend_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            filt_q     <= '1;
            filtClk_q  <= 1'b1;
            bitCnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            timer_q    <= '0;
            extPend_q  <= 1'b0;
            relPend_q  <= 1'b0;
            scancode_q <= 8'h00;
            extended_q <= 1'b0;
            released_q <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clkSync_q  <= {clkSync_q[0], clkps2};
            dataSync_q <= {dataSync_q[0], dataps2};
            filt_q     <= filt_d;
            filtClk_q  <= filtClk_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            timer_q    <= timer_d;
            extPend_q  <= extPend_d;
            relPend_q  <= relPend_d;
            scancode_q <= scancode_d;
            extended_q <= extended_d;
            released_q <= released_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign scancode       = scancode_q;
    assign extended       = extended_q;
    assign released       = released_q;
    assign scancode_valid = valid_q;
    assign frame_error    = error_q;

endmodule
